load_store_unit: RTL and testbench

Sits between the MIPS core's memory stage and the word-addressed data memory (100 × 32-bit words, combinational read, synchronous write). Translates byte-addressed load/store requests of byte, halfword or word size into word accesses. Sub-word stores use a two-cycle read-modify-write. Loads are sign- or zero-extended, and misaligned or out-of-range requests return an error response without touching memory.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/ls_lane_align.sv | 52 +++++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings (byte, halfword, word, reserved)
//   - FSM state type for the unit's control sequencer
//   - default data-memory depth in 32-bit words
//   - req_misaligned(): alignment and size legality check for a request
package lsu_pkg;

    localparam int MEM_WORDS_DEFAULT = 100;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } lsu_state_t;

    // True when the size is reserved or the byte offset does not suit the size.
    function automatic logic req_misaligned(input logic [1:0] size,
                                            input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = offset[0];
            SIZE_W:  bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ls_lane_align.sv
// ls_lane_align: combinational little-endian lane handling.
// Ports:
//   offset      in  2   byte offset within the word (addr[1:0])
//   size        in  2   access size (SIZE_B / SIZE_H / SIZE_W)
//   is_unsigned in  1   1 = zero-extend loads, 0 = sign-extend
//   word        in  32  current memory word
//   wdata       in  32  right-aligned store data
//   load_value  out 32  extracted and extended load result
//   merged_word out 32  word with the addressed lane replaced by wdata
module ls_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [4:0]  byte_shift;

    always_comb begin
        byte_shift  = {offset, 3'b000};
        byte_lane   = word[byte_shift +: 8];
        // Halfwords are only ever legal at offsets 0 and 2, so offset[1]
        // alone picks the lane.
        half_lane   = offset[1] ? word[31:16] : word[15:0];
        load_value  = word;
        merged_word = wdata;
        case (size)
            SIZE_B: begin
                load_value  = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
                merged_word = word;
                merged_word[byte_shift +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                load_value  = {{16{~is_unsigned & half_lane[15]}}, half_lane};
                merged_word = offset[1] ? {wdata[15:0], word[15:0]}
                                        : {word[31:16], wdata[15:0]};
            end
            default: begin
                load_value  = word;
                merged_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-addressed
// data memory (combinational read, synchronous write).
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   rsp_valid, rsp_rdata, rsp_err                         one-cycle response
//   mem_we, mem_a, mem_wd, mem_rd                         data-memory port
//   state_dbg             current FSM state, for observation only
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so request inputs
// are ignored at all other times. The response is a single-cycle rsp_valid
// pulse with no ready; the consumer must take it in that cycle.
//
// Sequencing: IDLE -> ACCESS -> RESP for loads and word stores,
// IDLE -> ACCESS -> WRITE -> RESP for sub-word stores (read-modify-write),
// IDLE -> RESP for any erroring request, which never reaches memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output lsu_state_t  state_dbg
);

    lsu_state_t  state;
    lsu_state_t  state_next;

    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] merged_q;

    logic        req_err;
    logic        lat_sub_word;
    logic [31:0] align_load;
    logic [31:0] align_merged;

    // Range check compares the full 30-bit word index, zero-extended.
    assign req_err = req_misaligned(req_size, req_addr[1:0])
                   | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    assign lat_sub_word = (lat_size != SIZE_W);
    assign state_dbg    = state;

    ls_lane_align u_align (
        .offset      (lat_addr[1:0]),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .word        (mem_rd),
        .wdata       (lat_wdata),
        .load_value  (align_load),
        .merged_word (align_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory/handshake outputs. Outputs depend only on the
    // state register and latched request, never on live inputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_a      = 32'h0;
        mem_wd     = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_a = {2'b00, lat_addr[31:2]};
                if (lat_we && !lat_sub_word) begin
                    mem_we = 1'b1;
                    mem_wd = lat_wdata;
                end
                state_next = (lat_we && lat_sub_word) ? WRITE : RESP;
            end
            WRITE: begin
                mem_a      = {2'b00, lat_addr[31:2]};
                mem_we     = 1'b1;
                mem_wd     = merged_q;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latches, merge register and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            merged_q     <= 32'h0;
            rsp_rdata    <= 32'h0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr;
                        lat_wdata    <= req_wdata;
                        rsp_err      <= req_err;
                        // Stores and errors respond with zero data.
                        rsp_rdata    <= 32'h0;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        rsp_rdata <= align_load;
                    end else if (lat_sub_word) begin
                        merged_q <= align_merged;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    lsu_state_t  state_dbg;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd),
        .state_dbg    (state_dbg)
    );

    // ---------------- data memory (environment) ----------------
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        pre_en;
    logic [6:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_we && mem_a < 32'(MEM_WORDS)) begin
            mem[mem_a[6:0]] <= mem_wd;
        end
    end

    assign mem_rd = (mem_a < 32'(MEM_WORDS)) ? mem[mem_a[6:0]] : 32'h0;

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    logic [31:0] exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
        logic [31:0] v;
        int sh;
        sh = int'(off) * 8;
        if (size == 2'b00) begin
            v = (w >> sh) & 32'h0000_00FF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (w >> sh) & 32'h0000_FFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] off, input logic [31:0] d);
        logic [31:0] m;
        int sh;
        if (size == 2'b10) return d;
        sh = int'(off) * 8;
        m  = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        return (w & ~(m << sh)) | ((d & m) << sh);
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = 7'(idx);
        pre_val = val;
        @(negedge clk);
        pre_en  = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] obs_rdata, output logic [31:0] obs_wd);
        logic        in_range;
        logic        exp_err;
        int          idx;
        int          exp_rsp;
        int          exp_we;
        logic [31:0] old_w;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        int          rsp_cyc;
        int          we_cyc;
        int          we_hits;
        logic [31:0] got_a;
        logic [31:0] got_wd;
        logic [31:0] got_rd;
        logic        got_err;

        in_range = (addr >> 2) < 32'(MEM_WORDS);
        idx      = in_range ? int'(addr >> 2) : 0;
        exp_err  = (size == 2'b11) || (size == 2'b01 && addr[0])
                || (size == 2'b10 && addr[1:0] != 2'b00) || !in_range;
        old_w    = ref_mem[idx];
        exp_rd   = 32'h0;
        exp_wd   = 32'h0;
        exp_we   = 0;
        if (exp_err) begin
            exp_rsp = 1;
        end else if (!we) begin
            exp_rsp = 2;
            exp_rd  = model_load(old_w, size, uns, addr[1:0]);
        end else begin
            exp_wd = model_store(old_w, size, addr[1:0], wdata);
            exp_we = (size == 2'b10) ? 1 : 2;
            exp_rsp = exp_we + 1;
        end
        exp_q.push_back(exp_rd);

        @(negedge clk);
        chk({tag, ":ready_idle"}, 32'(req_ready), 32'h1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        // Busy-time noise on the request fields must have no effect.
        req_valid    = 1'b0;
        req_we       = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;

        rsp_cyc = 0; we_cyc = 0; we_hits = 0;
        got_a = 32'h0; got_wd = 32'h0; got_rd = 32'h0; got_err = 1'b0;
        for (int c = 1; c <= 8 && rsp_cyc == 0; c++) begin
            @(negedge clk);
            chk({tag, ":ready_busy"}, 32'(req_ready), 32'h0);
            if (mem_we) begin
                we_hits++;
                if (we_cyc == 0) begin
                    we_cyc = c;
                    got_a  = mem_a;
                    got_wd = mem_wd;
                end
            end
            if (rsp_valid) begin
                rsp_cyc = c;
                got_err = rsp_err;
                got_rd  = rsp_rdata;
                chk({tag, ":resp_mem_a"}, mem_a, 32'h0);
                chk({tag, ":resp_mem_wd"}, mem_wd, 32'h0);
            end
        end
        chk({tag, ":rsp_latency"}, 32'(rsp_cyc), 32'(exp_rsp));
        chk({tag, ":rsp_err"}, 32'(got_err), 32'(exp_err));
        chk({tag, ":rsp_rdata"}, got_rd, exp_q.pop_front());
        chk({tag, ":we_cycle"}, 32'(we_cyc), 32'(exp_we));
        chk({tag, ":we_count"}, 32'(we_hits), (exp_we != 0) ? 32'h1 : 32'h0);
        if (exp_we != 0) begin
            chk({tag, ":mem_a"}, got_a, 32'(idx));
            chk({tag, ":mem_wd"}, got_wd, exp_wd);
            ref_mem[idx] = exp_wd;
        end

        @(negedge clk);
        chk({tag, ":rsp_one_cycle"}, 32'(rsp_valid), 32'h0);
        if (in_range) begin
            chk({tag, ":mem_word"}, mem[idx], ref_mem[idx]);
        end
        obs_rdata = got_rd;
        obs_wd    = got_wd;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic [31:0] wd;

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        pre_en = 1'b0; pre_idx = 7'h0; pre_val = 32'h0;

        repeat (3) @(negedge clk);
        chk("reset:state", 32'(state_dbg), 32'(IDLE));
        chk("reset:req_ready", 32'(req_ready), 32'h1);
        chk("reset:rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset:rsp_err", 32'(rsp_err), 32'h0);
        chk("reset:rsp_rdata", rsp_rdata, 32'h0);
        chk("reset:mem_we", 32'(mem_we), 32'h0);
        chk("reset:mem_a", mem_a, 32'h0);
        chk("reset:mem_wd", mem_wd, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < MEM_WORDS; i++) preload(i, $urandom);

        // Directed test plan
        do_req("sw_0x8", 1'b1, SIZE_W, 1'b0, 32'h8, 32'h1234_5678, rd, wd);
        chk("sw_0x8:wd_const", wd, 32'h1234_5678);
        do_req("lb_0xb_s", 1'b0, SIZE_B, 1'b0, 32'hB, 32'h0, rd, wd);
        chk("lb_0xb_s:const", rd, 32'h0000_0012);
        preload(2, 32'h8034_5678);
        do_req("lb_0xb_neg", 1'b0, SIZE_B, 1'b0, 32'hB, 32'h0, rd, wd);
        chk("lb_0xb_neg:const", rd, 32'hFFFF_FF80);
        do_req("lbu_0xb", 1'b0, SIZE_B, 1'b1, 32'hB, 32'h0, rd, wd);
        chk("lbu_0xb:const", rd, 32'h0000_0080);
        preload(2, 32'h1234_5678);
        do_req("sb_0x9", 1'b1, SIZE_B, 1'b0, 32'h9, 32'h0000_00AB, rd, wd);
        chk("sb_0x9:wd_const", wd, 32'h1234_AB78);
        preload(2, 32'h1234_5678);
        do_req("sh_0xa", 1'b1, SIZE_H, 1'b0, 32'hA, 32'h0000_BEEF, rd, wd);
        chk("sh_0xa:wd_const", wd, 32'hBEEF_5678);
        do_req("lh_0xa_s", 1'b0, SIZE_H, 1'b0, 32'hA, 32'h0, rd, wd);
        chk("lh_0xa_s:const", rd, 32'hFFFF_BEEF);
        do_req("err_lh_0x5", 1'b0, SIZE_H, 1'b0, 32'h5, 32'h0, rd, wd);
        do_req("err_sw_idx100", 1'b1, SIZE_W, 1'b0, 32'h190, 32'hDEAD_BEEF, rd, wd);
        do_req("err_size11", 1'b0, SIZE_RSV, 1'b0, 32'h0, 32'h0, rd, wd);
        do_req("sw_last", 1'b1, SIZE_W, 1'b0, 32'h18C, 32'hA5A5_5A5A, rd, wd);

        // Reset asserted during the WRITE cycle of a sub-word store
        preload(3, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_B; req_unsigned = 1'b0;
        req_addr = 32'hC; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid:access_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        chk("rst_mid:write_we", 32'(mem_we), 32'h1);
        reset = 1'b0;
        #1;
        chk("rst_mid:we_drop", 32'(mem_we), 32'h0);
        chk("rst_mid:rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_mid:ready", 32'(req_ready), 32'h1);
        chk("rst_mid:rdata", rsp_rdata, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid:no_rsp", 32'(rsp_valid), 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid:ready_after", 32'(req_ready), 32'h1);
        chk("rst_mid:mem_kept", mem[3], 32'hCAFE_F00D);
        do_req("rst_mid:reload", 1'b0, SIZE_W, 1'b0, 32'hC, 32'h0, rd, wd);
        chk("rst_mid:reload_const", rd, 32'hCAFE_F00D);

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 419));
            do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom, rd, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
